axis_rr_pkt_arbiter: RTL
========================

Name: axis_rr_pkt_arbiter

Overview:
- Packet-level round-robin arbiter sharing one AXI-Stream FIFO input among NUM_SRC requesters.
- Sits directly upstream of the team's parameterised AXIS FIFO and drives its write-side AXIS interface.
- Locks the grant from a packet's first beat through its tlast, so packets are never interleaved.
- Tags every output beat with the source index on tid; registered output (one slice).

Parameters:
- NUM_SRC, 4, number of requesters; 2..16.
- WIDTH_TDATA, 16, tdata width per beat.
- WIDTH_TUSER, 4, tuser width per beat, passed through unchanged.
- SRC_W, $clog2(NUM_SRC), derived localparam; width of the source index and of axis_m_tid.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- axis_s_tvalid  in  NUM_SRC  per-source valid.
- axis_s_tdata  in  NUM_SRC*WIDTH_TDATA  flattened; source i occupies bits [i*WIDTH_TDATA +: WIDTH_TDATA].
- axis_s_tuser  in  NUM_SRC*WIDTH_TUSER  flattened, same packing rule.
- axis_s_tlast  in  NUM_SRC  per-source end of packet.
- axis_s_tready  out  NUM_SRC  per-source ready; at most one bit high at a time.
- axis_m_tvalid  out  1  output valid, to the FIFO.
- axis_m_tdata  out  WIDTH_TDATA  output data.
- axis_m_tuser  out  WIDTH_TUSER  output user bits.
- axis_m_tid  out  SRC_W  index of the originating source.
- axis_m_tlast  out  1  output end of packet.
- axis_m_tready  in  1  FIFO ready.
- busy  out  1  high while a packet is in progress (state LOCK).

Behaviour:
- Reset, one cycle, synchronous:
  - axis_m_tvalid=0; axis_m_tdata, axis_m_tuser, axis_m_tid and axis_m_tlast = 0.
  - state=IDLE; rr_ptr=NUM_SRC-1, so source 0 has top priority first; busy=0.
- Output slice:
  - out_ready = !axis_m_tvalid || axis_m_tready.
  - When a beat is accepted, the slice loads data/user/last and tid=source index, and sets axis_m_tvalid=1.
  - If axis_m_tready is high with no new beat accepted, the slice clears axis_m_tvalid.
  - Latency: input handshake to axis_m_tvalid = 1 cycle. Full throughput: 1 beat/cycle with axis_m_tready held high.
- axis_m_* stays stable while axis_m_tvalid=1 and axis_m_tready=0 (AXIS rule).
- axis_s_tready[i] = out_ready && (i == cur_sel), where:
  - In IDLE, cur_sel = the round-robin winner, and is valid only if any axis_s_tvalid bit is set.
  - In LOCK, cur_sel = lock_sel.
- Round-robin winner: the first source with tvalid set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_SRC.
- State IDLE:
  - No valid source, or out_ready=0: no transfer, stay IDLE.
  - Transfer with tlast=1 (single-beat packet): stay IDLE, rr_ptr <= winner.
  - Transfer with tlast=0: go to LOCK, lock_sel <= winner.
- State LOCK (busy=1):
  - Only lock_sel may transfer.
  - Other sources' tvalid is ignored; their tready stays 0.
  - Transfer with tlast=1: go to IDLE, rr_ptr <= lock_sel.
  - The locked source deasserting tvalid mid-packet: hold LOCK indefinitely; no timeout.
- rr_ptr changes only on packet completion. The next arbitration happens in the IDLE cycle after the tlast beat, so there is one dead cycle between multi-beat packets.
- Back-pressure:
  - axis_m_tready=0 with axis_m_tvalid=1 forces all axis_s_tready=0.
  - The grant and the lock are unaffected by back-pressure.
- Asserting rst mid-packet aborts the partial packet; no tlast is emitted. Downstream flushes separately.
- Sources must hold tvalid/tdata until their tready; the arbiter does not buffer beyond the slice.

Decomposition:
- Package axis_arb_pkg holds:
  - enum arb_state_t {IDLE, LOCK};
  - function rr_pick(req, ptr) returning the winning index plus a found flag.
- One sub-module: axis_rr_arbiter_core.
  - Combinational round-robin pick, plus the rr_ptr register updated on an advance strobe.
  - Reusable by other shared-resource blocks.

Test Plan:
- Single source, NUM_SRC=4: src2 sends 3 beats 0x0011, 0x0022, 0x0033 (tlast on the last) -> axis_m_* shows the same 3 beats, tid=2 throughout, first beat one cycle after handshake, busy=1 during beats 1-2.
- All four sources valid with 2-beat packets, axis_m_tready=1 -> tid order 0,1,2,3,0. No interleaving. One idle cycle between packets.
- Source 1 in LOCK mid-packet and stalls tvalid for 5 cycles while source 3 is valid -> axis_s_tready[3]=0 throughout; source 1 resumes and its tlast completes; the next grant goes to 3.
- Back-pressure: axis_m_tready toggled 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; axis_m_* stable while stalled; all axis_s_tready=0 in stall cycles.
- Single-beat packets (tlast=1) from sources 0 and 3 simultaneously after reset -> 0 first, then 3; rr_ptr ends at 3; state never leaves IDLE.
- rst asserted during beat 2 of a 4-beat packet from source 1 -> next cycle: axis_m_tvalid=0, busy=0, rr_ptr=3; a subsequent request from source 2 is granted normally.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the AXIS packet arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  localparam int RR_MAX_SRC = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Scans ptr+1, ptr+2, ... modulo num_src. Walking from the far end toward
  // ptr+1 lets the nearest requester overwrite the result last.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                       input logic [3:0] ptr,
                                       input int num_src);
    rr_pick_t r;
    int       c;
    r.found = 1'b0;
    r.idx   = ptr;
    for (int k = RR_MAX_SRC; k >= 1; k--) begin
      if (k <= num_src) begin
        c = (int'(ptr) + k) % num_src;
        if (req[c[3:0]]) begin
          r.found = 1'b1;
          r.idx   = c[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_core.sv
// Round-robin pick over a request vector, with the priority pointer updated
// only when the owner of the shared resource signals completion.
module axis_rr_arbiter_core
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  input  logic [SRC_W-1:0]   advance_idx,
  output logic [SRC_W-1:0]   winner,
  output logic               found
);

  logic [SRC_W-1:0]      rr_ptr;
  logic [RR_MAX_SRC-1:0] req_ext;
  rr_pick_t              pick;

  always_comb begin
    req_ext = RR_MAX_SRC'(req);
    pick    = rr_pick(req_ext, 4'(rr_ptr), NUM_SRC);
    winner  = SRC_W'(pick.idx);
    found   = pick.found;
  end

  // Reset points at the last source so source 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= SRC_W'(NUM_SRC - 1);
    end else if (advance) begin
      rr_ptr <= advance_idx;
    end
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: grants are held from first beat
// through tlast, output goes through one register slice tagged with tid.
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int WIDTH_TDATA = 16,
  parameter  int WIDTH_TUSER = 4,
  localparam int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             axis_s_tvalid,
  input  logic [NUM_SRC*WIDTH_TDATA-1:0] axis_s_tdata,
  input  logic [NUM_SRC*WIDTH_TUSER-1:0] axis_s_tuser,
  input  logic [NUM_SRC-1:0]             axis_s_tlast,
  output logic [NUM_SRC-1:0]             axis_s_tready,
  output logic                           axis_m_tvalid,
  output logic [WIDTH_TDATA-1:0]         axis_m_tdata,
  output logic [WIDTH_TUSER-1:0]         axis_m_tuser,
  output logic [SRC_W-1:0]               axis_m_tid,
  output logic                           axis_m_tlast,
  input  logic                           axis_m_tready,
  output logic                           busy
);

  arb_state_t       state, state_next;
  logic [SRC_W-1:0] lock_sel, lock_sel_next;
  logic [SRC_W-1:0] winner, cur_sel, advance_idx;
  logic             found, grant_ok, out_ready, accept, advance;
  logic             gap, gap_next;
  logic [WIDTH_TDATA-1:0] sel_data;
  logic [WIDTH_TUSER-1:0] sel_user;
  logic                   sel_last;

  axis_rr_arbiter_core #(.NUM_SRC(NUM_SRC)) u_core (
    .clk         (clk),
    .rst         (rst),
    .req         (axis_s_tvalid),
    .advance     (advance),
    .advance_idx (advance_idx),
    .winner      (winner),
    .found       (found)
  );

  // gap blocks arbitration for the single dead cycle after a multi-beat packet.
  always_comb begin
    out_ready = !axis_m_tvalid || axis_m_tready;
    cur_sel   = (state == LOCK) ? lock_sel : winner;
    grant_ok  = (state == LOCK) ? 1'b1 : (found && !gap);
    accept    = out_ready && grant_ok && axis_s_tvalid[cur_sel];
    sel_data  = axis_s_tdata[cur_sel*WIDTH_TDATA +: WIDTH_TDATA];
    sel_user  = axis_s_tuser[cur_sel*WIDTH_TUSER +: WIDTH_TUSER];
    sel_last  = axis_s_tlast[cur_sel];
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ready
    assign axis_s_tready[i] = out_ready && grant_ok && (cur_sel == SRC_W'(i));
  end

  always_comb begin
    state_next    = state;
    lock_sel_next = lock_sel;
    gap_next      = 1'b0;
    advance       = 1'b0;
    advance_idx   = cur_sel;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            advance = 1'b1;
          end else begin
            state_next    = LOCK;
            lock_sel_next = winner;
          end
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          advance    = 1'b1;
          state_next = IDLE;
          gap_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      gap      <= 1'b0;
    end else begin
      state    <= state_next;
      lock_sel <= lock_sel_next;
      gap      <= gap_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tuser  <= '0;
      axis_m_tid    <= '0;
      axis_m_tlast  <= 1'b0;
    end else if (accept) begin
      axis_m_tvalid <= 1'b1;
      axis_m_tdata  <= sel_data;
      axis_m_tuser  <= sel_user;
      axis_m_tid    <= cur_sel;
      axis_m_tlast  <= sel_last;
    end else if (axis_m_tready) begin
      axis_m_tvalid <= 1'b0;
    end
  end

  assign busy = (state == LOCK);

endmodule
